// File: rtl/vend_machine_param.sv
`default_nettype none
// ============================================================================
//  Module   : vend_machine_param
//  Purpose  : Multi-product vending controller. It holds a saturating credit
//             in 0.5-yuan units, accepts or rejects coins, grants or refuses
//             buy requests against per-product prices, and pays out change
//             one unit per chg_pulse on alternate cycles.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             coin_vld/coin_val  - coin present / coin value in units
//             buy/sel            - purchase request / product index
//             cancel             - refund request (only with VEND_CANCEL_EN)
//             coin_acc/coin_rej  - 1-cycle coin accept / reject pulses
//             buy_nak            - 1-cycle buy refused pulse
//             vend_vld/vend_id   - 1-cycle dispense pulse / product (held)
//             chg_pulse          - one pulse per change unit returned
//             busy               - high while vending or paying change
//             credit             - current credit
//  Macro    : VEND_CANCEL_EN adds the cancel port and full-credit refund.
//  Revision : 1.0 - initial release
// ============================================================================
module vend_machine_param #(
   parameter int                      NPROD      = 2,
   parameter int                      SEL_W      = 1,
   parameter int                      COIN_W     = 3,
   parameter int                      CRED_W     = 6,
   parameter int                      MAX_CREDIT = 40,
   parameter logic [NPROD*CRED_W-1:0] PRICE_LIST = {6'd5, 6'd3}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              coin_vld,
   input  logic [COIN_W-1:0] coin_val,
   input  logic              buy,
   input  logic [SEL_W-1:0]  sel,
`ifdef VEND_CANCEL_EN
   input  logic              cancel,
`endif
   output logic              coin_acc,
   output logic              coin_rej,
   output logic              buy_nak,
   output logic              vend_vld,
   output logic [SEL_W-1:0]  vend_id,
   output logic              chg_pulse,
   output logic              busy,
   output logic [CRED_W-1:0] credit
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CREDIT = 2'd1,
      S_VEND   = 2'd2,
      S_CHANGE = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_nxt_state;
   logic [CRED_W-1:0]   w_nxt_credit;
   logic                w_nxt_acc;
   logic                w_nxt_rej;
   logic                w_nxt_nak;
   logic                w_nxt_vend;
   logic [SEL_W-1:0]    w_nxt_id;
   logic                w_nxt_chg;
   logic                w_nxt_busy;

   logic [CRED_W-1:0]   w_price;
   logic                w_sel_ok;
   logic                w_buy_ok;
   logic [CRED_W:0]     w_sum;
   logic                w_coin_ok;
   logic                w_cancel;

   // Price lookup; an out-of-range sel yields 0 but is refused via w_sel_ok.
   always_comb begin
      w_price = '0;
      for (int i = 0; i < NPROD; i++) begin
         if (32'(sel) == i) begin
            w_price = PRICE_LIST[i*CRED_W +: CRED_W];
         end
      end
   end

   assign w_sel_ok  = (32'(sel) < NPROD);
   assign w_buy_ok  = w_sel_ok && (credit >= w_price);
   // One extra bit so the saturation test cannot wrap.
   assign w_sum     = {1'b0, credit} + (CRED_W+1)'(coin_val);
   assign w_coin_ok = (coin_val != '0) && (w_sum <= (CRED_W+1)'(MAX_CREDIT));

`ifdef VEND_CANCEL_EN
   // Only meaningful with credit held; in IDLE there is nothing to refund.
   assign w_cancel  = (r_state == S_CREDIT) && cancel;
`else
   assign w_cancel  = 1'b0;
`endif

   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_credit = credit;
      w_nxt_acc    = 1'b0;
      w_nxt_rej    = 1'b0;
      w_nxt_nak    = 1'b0;
      w_nxt_vend   = 1'b0;
      w_nxt_id     = vend_id;
      w_nxt_chg    = 1'b0;

      case (r_state)
         S_IDLE, S_CREDIT: begin
            if (w_cancel) begin
               // Cancel wins over anything else presented this cycle.
               w_nxt_state = S_CHANGE;
               w_nxt_rej   = coin_vld;
               w_nxt_nak   = buy;
            end else if (buy && w_buy_ok) begin
               // Granted buy is judged on pre-coin credit; a coin alongside is returned.
               w_nxt_state  = S_VEND;
               w_nxt_vend   = 1'b1;
               w_nxt_id     = sel;
               w_nxt_credit = credit - w_price;
               w_nxt_rej    = coin_vld;
            end else begin
               w_nxt_nak = buy;
               if (coin_vld) begin
                  if (w_coin_ok) begin
                     w_nxt_credit = w_sum[CRED_W-1:0];
                     w_nxt_acc    = 1'b1;
                  end else begin
                     w_nxt_rej    = 1'b1;
                  end
               end
               w_nxt_state = (w_nxt_credit == '0) ? S_IDLE : S_CREDIT;
            end
         end
         S_VEND: begin
            w_nxt_rej   = coin_vld;
            w_nxt_nak   = buy;
            w_nxt_state = (credit != '0) ? S_CHANGE : S_IDLE;
         end
         S_CHANGE: begin
            w_nxt_rej = coin_vld;
            w_nxt_nak = buy;
            // Alternate pulse / gap; the registered chg_pulse is the phase bit.
            if (!chg_pulse && (credit != '0)) begin
               w_nxt_chg    = 1'b1;
               w_nxt_credit = credit - 1'b1;
            end else if (credit == '0) begin
               w_nxt_state  = S_IDLE;
            end
         end
         default: begin
            w_nxt_state = S_IDLE;
         end
      endcase

      w_nxt_busy = (w_nxt_state == S_VEND) || (w_nxt_state == S_CHANGE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         credit    <= '0;
         coin_acc  <= 1'b0;
         coin_rej  <= 1'b0;
         buy_nak   <= 1'b0;
         vend_vld  <= 1'b0;
         vend_id   <= '0;
         chg_pulse <= 1'b0;
         busy      <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         credit    <= w_nxt_credit;
         coin_acc  <= w_nxt_acc;
         coin_rej  <= w_nxt_rej;
         buy_nak   <= w_nxt_nak;
         vend_vld  <= w_nxt_vend;
         vend_id   <= w_nxt_id;
         chg_pulse <= w_nxt_chg;
         busy      <= w_nxt_busy;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vend_machine_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vend_machine_param
//  Purpose  : Directed self-checking bench for vend_machine_param with the
//             default parameters (prices 3 and 5, max credit 40). Each step
//             drives one cycle of inputs, queues the expected registered
//             outputs, and compares them one cycle later.
//  Macro    : VEND_CANCEL_EN selects the cancel-enabled expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vend_machine_param;

   typedef struct packed {
      logic       acc;
      logic       rej;
      logic       nak;
      logic       vend;
      logic [0:0] id;
      logic       chg;
      logic       busy;
      logic [5:0] cr;
   } out_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       coin_vld;
   logic [2:0] coin_val;
   logic       buy;
   logic [0:0] sel;
   logic       cancel;
   logic       coin_acc, coin_rej, buy_nak, vend_vld, chg_pulse, busy;
   logic [0:0] vend_id;
   logic [5:0] credit;

   out_t  exp_q[$];
   string tag_q[$];
   int    total = 0;
   int    bad   = 0;

   vend_machine_param dut (
      .clk       (clk),
      .rst       (rst),
      .coin_vld  (coin_vld),
      .coin_val  (coin_val),
      .buy       (buy),
      .sel       (sel),
`ifdef VEND_CANCEL_EN
      .cancel    (cancel),
`endif
      .coin_acc  (coin_acc),
      .coin_rej  (coin_rej),
      .buy_nak   (buy_nak),
      .vend_vld  (vend_vld),
      .vend_id   (vend_id),
      .chg_pulse (chg_pulse),
      .busy      (busy),
      .credit    (credit)
   );

   always #5 clk = ~clk;

   function automatic out_t mk(input logic acc, input logic rej, input logic nak,
                               input logic vend, input logic id, input logic chg,
                               input logic bsy, input logic [5:0] cr);
      out_t o;
      o.acc  = acc;
      o.rej  = rej;
      o.nak  = nak;
      o.vend = vend;
      o.id   = id;
      o.chg  = chg;
      o.busy = bsy;
      o.cr   = cr;
      return o;
   endfunction

   // Drive one cycle of inputs, queue the expectation, check after the edge.
   task automatic step(input string tag, input logic cv, input logic [2:0] val,
                       input logic b, input logic s, input logic c, input out_t e);
      out_t  obs;
      out_t  ex;
      string t;
      coin_vld = cv;
      coin_val = val;
      buy      = b;
      sel      = s;
      cancel   = c;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      obs = {coin_acc, coin_rej, buy_nak, vend_vld, vend_id, chg_pulse, busy, credit};
      ex  = exp_q.pop_front();
      t   = tag_q.pop_front();
      total++;
      assert (obs === ex) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", t, obs, ex);
      end
   endtask

   task automatic idle(input string tag, input out_t e);
      step(tag, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      coin_vld = 1'b0; coin_val = '0; buy = 1'b0; sel = '0; cancel = 1'b0;
      @(negedge clk);
      idle("reset", mk(0,0,0,0,0,0,0,6'd0));
      rst = 1'b0;

      // 1: three single-unit coins, buy product 0 (price 3), no change
      step("t1_coin1", 1, 3'd1, 0, 0, 0, mk(1,0,0,0,0,0,0,6'd1));
      step("t1_coin2", 1, 3'd1, 0, 0, 0, mk(1,0,0,0,0,0,0,6'd2));
      step("t1_coin3", 1, 3'd1, 0, 0, 0, mk(1,0,0,0,0,0,0,6'd3));
      step("t1_buy",   0, 3'd0, 1, 0, 0, mk(0,0,0,1,0,0,1,6'd0));
      idle("t1_idle",  mk(0,0,0,0,0,0,0,6'd0));

      // 2: 6 units, buy product 1 (price 5), one unit of change
      step("t2_coin1", 1, 3'd2, 0, 0, 0, mk(1,0,0,0,0,0,0,6'd2));
      step("t2_coin2", 1, 3'd2, 0, 0, 0, mk(1,0,0,0,0,0,0,6'd4));
      step("t2_coin3", 1, 3'd2, 0, 0, 0, mk(1,0,0,0,0,0,0,6'd6));
      step("t2_buy",   0, 3'd0, 1, 1, 0, mk(0,0,0,1,1,0,1,6'd1));
      idle("t2_chg_entry", mk(0,0,0,0,1,0,1,6'd1));
      idle("t2_chg_pulse", mk(0,0,0,0,1,1,1,6'd0));
      idle("t2_back_idle", mk(0,0,0,0,1,0,0,6'd0));

      // 3: refused buy, coin+refused buy, then coin+granted buy
      step("t3_coin",      1, 3'd2, 0, 0, 0, mk(1,0,0,0,1,0,0,6'd2));
      step("t3_nak",       0, 3'd0, 1, 1, 0, mk(0,0,1,0,1,0,0,6'd2));
      step("t3_coin_nak",  1, 3'd2, 1, 0, 0, mk(1,0,1,0,1,0,0,6'd4));
      step("t3_buy",       0, 3'd0, 1, 0, 0, mk(0,0,0,1,0,0,1,6'd1));
      idle("t3_chg_entry", mk(0,0,0,0,0,0,1,6'd1));
      idle("t3_chg_pulse", mk(0,0,0,0,0,1,1,6'd0));
      idle("t3_idle",      mk(0,0,0,0,0,0,0,6'd0));
      step("t3_coin_a",    1, 3'd2, 0, 0, 0, mk(1,0,0,0,0,0,0,6'd2));
      step("t3_coin_b",    1, 3'd2, 0, 0, 0, mk(1,0,0,0,0,0,0,6'd4));
      step("t3_coin_buy",  1, 3'd2, 1, 0, 0, mk(0,1,0,1,0,0,1,6'd1));
      step("t3_busy_rej",  1, 3'd1, 1, 0, 0, mk(0,1,1,0,0,0,1,6'd1));
      idle("t3_chg_pulse2", mk(0,0,0,0,0,1,1,6'd0));
      idle("t3_idle2",     mk(0,0,0,0,0,0,0,6'd0));

      // 4: saturation at 40 and zero-value coin
      for (int k = 0; k < 5; k++) begin
         step("t4_fill", 1, 3'd7, 0, 0, 0, mk(1,0,0,0,0,0,0,6'(7*(k+1))));
      end
      step("t4_to39",  1, 3'd4, 0, 0, 0, mk(1,0,0,0,0,0,0,6'd39));
      step("t4_over",  1, 3'd2, 0, 0, 0, mk(0,1,0,0,0,0,0,6'd39));
      step("t4_to40",  1, 3'd1, 0, 0, 0, mk(1,0,0,0,0,0,0,6'd40));
      step("t4_zero",  1, 3'd0, 0, 0, 0, mk(0,1,0,0,0,0,0,6'd40));
      rst = 1'b1;
      idle("t4_reset", mk(0,0,0,0,0,0,0,6'd0));
      rst = 1'b0;

      // 5: reset in the middle of a change payout
      step("t5_coin7", 1, 3'd7, 0, 0, 0, mk(1,0,0,0,0,0,0,6'd7));
      step("t5_coin3", 1, 3'd3, 0, 0, 0, mk(1,0,0,0,0,0,0,6'd10));
      step("t5_buy",   0, 3'd0, 1, 0, 0, mk(0,0,0,1,0,0,1,6'd7));
      idle("t5_entry", mk(0,0,0,0,0,0,1,6'd7));
      idle("t5_p1",    mk(0,0,0,0,0,1,1,6'd6));
      idle("t5_g1",    mk(0,0,0,0,0,0,1,6'd6));
      idle("t5_p2",    mk(0,0,0,0,0,1,1,6'd5));
      rst = 1'b1;
      idle("t5_rst",   mk(0,0,0,0,0,0,0,6'd0));
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         idle("t5_quiet", mk(0,0,0,0,0,0,0,6'd0));
      end

      // 6: cancel
      step("t6_coin4", 1, 3'd4, 0, 0, 0, mk(1,0,0,0,0,0,0,6'd4));
`ifdef VEND_CANCEL_EN
      step("t6_cancel", 1, 3'd1, 1, 0, 1, mk(0,1,1,0,0,0,1,6'd4));
      for (int k = 3; k >= 0; k--) begin
         idle("t6_pulse", mk(0,0,0,0,0,1,1,6'(k)));
         if (k > 0) idle("t6_gap", mk(0,0,0,0,0,0,1,6'(k)));
      end
      idle("t6_idle", mk(0,0,0,0,0,0,0,6'd0));
      step("t6_cancel_idle", 0, 3'd0, 0, 0, 1, mk(0,0,0,0,0,0,0,6'd0));
`else
      step("t6_cancel_ign", 0, 3'd0, 0, 0, 1, mk(0,0,0,0,0,0,0,6'd4));
      for (int k = 0; k < 4; k++) begin
         idle("t6_keep", mk(0,0,0,0,0,0,0,6'd4));
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
